// File: rtl/prog_rom_arb_pkg.sv
// Shared types for the program-ROM arbiter: requester ids, in-flight tag
// layout and the starvation counter width.
package prog_rom_arb_pkg;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_LD = 1'b1
   } port_e;

   localparam int ROM_RD_LATENCY = 1;

   typedef struct packed {
      logic  valid;
      port_e port;
      logic  err;
   } inflight_t;

   // Enough bits to hold 0..limit inclusive; never narrower than one bit.
   function automatic int starve_cnt_w(input int limit);
      if (limit < 1) return 1;
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/rom_rsp_slot.sv
// One-entry response holding register with bypass; the ROM word passes straight
// through when the consumer is ready and is parked here when it is not.
module rom_rsp_slot
   import prog_rom_arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_err,
   input  logic              flush,
   input  logic              rsp_ready,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              err,
   output logic              full
);

   logic              full_q;
   logic [DATA_W-1:0] data_q;
   logic              err_q;

   // A flush hides both the parked word and the one arriving this cycle.
   assign valid = (full_q | in_valid) & ~flush;
   assign data  = full_q ? data_q : in_data;
   assign err   = full_q ? err_q  : in_err;
   assign full  = full_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         full_q <= 1'b0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else if (flush) begin
         full_q <= 1'b0;
      end else if (full_q) begin
         if (rsp_ready) full_q <= 1'b0;
      end else if (in_valid && !rsp_ready) begin
         full_q <= 1'b1;
         data_q <= in_data;
         err_q  <= in_err;
      end
   end

endmodule

// File: rtl/prog_rom_arbiter.sv
// Two-port arbiter in front of the single-port program ROM: fetch has priority,
// loads are guaranteed a grant after STARVE_LIMIT consecutive losses.
module prog_rom_arbiter
   import prog_rom_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              IF_REQ_VALID,
   output logic              IF_REQ_READY,
   input  logic [ADDR_W-1:0] IF_ADDR,
   input  logic              IF_FLUSH,
   output logic              IF_RSP_VALID,
   input  logic              IF_RSP_READY,
   output logic [DATA_W-1:0] IF_RSP_DATA,
   input  logic              LD_REQ_VALID,
   output logic              LD_REQ_READY,
   input  logic [ADDR_W-1:0] LD_ADDR,
   output logic              LD_RSP_VALID,
   input  logic              LD_RSP_READY,
   output logic [DATA_W-1:0] LD_RSP_DATA,
   output logic              LD_RSP_ERR,
   output logic [ADDR_W-1:0] ROM_ADDR,
   input  logic [DATA_W-1:0] ROM_DATA
);

   localparam int                  STARVE_W   = starve_cnt_w(STARVE_LIMIT);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   inflight_t           tag_q;
   logic [STARVE_W-1:0] starve_cnt_q;
   logic [ADDR_W-1:0]   last_addr_q;

   logic if_full;
   logic ld_full;
   logic if_tag_hit;
   logic ld_tag_hit;
   logic if_elig;
   logic ld_elig;
   logic if_cand;
   logic ld_cand;
   logic if_win;
   logic ld_win;
   logic ld_misaligned;
   logic if_rsp_err;

   assign if_tag_hit    = tag_q.valid && (tag_q.port == PORT_IF);
   assign ld_tag_hit    = tag_q.valid && (tag_q.port == PORT_LD);
   assign ld_misaligned = (LD_ADDR[1:0] != 2'b00);

   // A port may only be granted if its response next cycle has somewhere to go:
   // nothing parked, and this cycle's response (if any) is being consumed.
   always_comb begin
      if_elig = !if_full && !(if_tag_hit && !IF_RSP_READY);
      ld_elig = !ld_full && !(ld_tag_hit && !LD_RSP_READY);
      if_cand = RST_N && IF_REQ_VALID && if_elig;
      ld_cand = RST_N && LD_REQ_VALID && ld_elig;
      ld_win  = ld_cand && (!if_cand || (starve_cnt_q == STARVE_MAX));
      if_win  = if_cand && !ld_win;
   end

   assign IF_REQ_READY = if_win;
   assign LD_REQ_READY = ld_win;
   assign ROM_ADDR     = if_win ? IF_ADDR : (ld_win ? LD_ADDR : last_addr_q);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tag_q        <= '0;
         starve_cnt_q <= '0;
         last_addr_q  <= '0;
      end else begin
         tag_q.valid <= if_win || ld_win;
         tag_q.port  <= ld_win ? PORT_LD : PORT_IF;
         tag_q.err   <= ld_win && ld_misaligned;

         if (if_win || ld_win) last_addr_q <= ROM_ADDR;

         if (!LD_REQ_VALID || ld_win) begin
            starve_cnt_q <= '0;
         end else if (ld_cand && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
         end
      end
   end

   rom_rsp_slot #(
      .DATA_W (DATA_W)
   ) u_if_slot (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_valid  (if_tag_hit),
      .in_data   (ROM_DATA),
      .in_err    (1'b0),
      .flush     (IF_FLUSH),
      .rsp_ready (IF_RSP_READY),
      .valid     (IF_RSP_VALID),
      .data      (IF_RSP_DATA),
      .err       (if_rsp_err),
      .full      (if_full)
   );

   rom_rsp_slot #(
      .DATA_W (DATA_W)
   ) u_ld_slot (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_valid  (ld_tag_hit),
      .in_data   (ROM_DATA),
      .in_err    (tag_q.err),
      .flush     (1'b0),
      .rsp_ready (LD_RSP_READY),
      .valid     (LD_RSP_VALID),
      .data      (LD_RSP_DATA),
      .err       (LD_RSP_ERR),
      .full      (ld_full)
   );

   // Fetch responses never carry an error; a set flag means a corrupted tag.
   always_comb begin
      if (RST_N) assert (!(IF_RSP_VALID && if_rsp_err));
   end

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// Randomised and directed bench for prog_rom_arbiter against a queue-based
// model of per-port outstanding responses.
module tb_prog_rom_arbiter;

   localparam int STARVE_LIMIT = 4;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        IF_REQ_VALID, IF_REQ_READY, IF_FLUSH, IF_RSP_VALID, IF_RSP_READY;
   logic [31:0] IF_ADDR, IF_RSP_DATA;
   logic        LD_REQ_VALID, LD_REQ_READY, LD_RSP_VALID, LD_RSP_READY, LD_RSP_ERR;
   logic [31:0] LD_ADDR, LD_RSP_DATA;
   logic [31:0] ROM_ADDR, ROM_DATA;

   always #5 CLK = ~CLK;

   prog_rom_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .IF_REQ_VALID (IF_REQ_VALID),
      .IF_REQ_READY (IF_REQ_READY),
      .IF_ADDR      (IF_ADDR),
      .IF_FLUSH     (IF_FLUSH),
      .IF_RSP_VALID (IF_RSP_VALID),
      .IF_RSP_READY (IF_RSP_READY),
      .IF_RSP_DATA  (IF_RSP_DATA),
      .LD_REQ_VALID (LD_REQ_VALID),
      .LD_REQ_READY (LD_REQ_READY),
      .LD_ADDR      (LD_ADDR),
      .LD_RSP_VALID (LD_RSP_VALID),
      .LD_RSP_READY (LD_RSP_READY),
      .LD_RSP_DATA  (LD_RSP_DATA),
      .LD_RSP_ERR   (LD_RSP_ERR),
      .ROM_ADDR     (ROM_ADDR),
      .ROM_DATA     (ROM_DATA)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          rdy;
   } rsp_t;

   rsp_t        q_if[$];
   rsp_t        q_ld[$];
   int          cyc = 0;
   int          starve = 0;
   logic [31:0] last_addr = '0;
   int          checks = 0;
   int          failures = 0;

   logic        s_if_req_ready, s_ld_req_ready, s_if_rsp_valid, s_ld_rsp_valid, s_ld_rsp_err;
   logic [31:0] s_rom_addr, s_if_rsp_data, s_ld_rsp_data;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [13:0] idx;
      idx = a[15:2];
      return {2'b10, idx, ~idx, 2'b01};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_if.delete();
      q_ld.delete();
      starve    = 0;
      last_addr = '0;
   endtask

   // One clock cycle: drive, check against the model mid-cycle, advance model.
   // Entered and left at posedge+1.
   task automatic cycle(input logic ifv, input logic [31:0] ifa, input logic ifl,
                        input logic ifr, input logic ldv, input logic [31:0] lda,
                        input logic ldr);
      logic        if_el, ld_el, if_w, ld_w, e_ifv, e_ldv;
      logic [31:0] e_addr;
      IF_REQ_VALID = ifv;
      IF_ADDR      = ifa;
      IF_FLUSH     = ifl;
      IF_RSP_READY = ifr;
      LD_REQ_VALID = ldv;
      LD_ADDR      = lda;
      LD_RSP_READY = ldr;
      #4;
      // a port can take a new grant only if nothing of its own is still unread
      // after this cycle
      if_el = (q_if.size() == 0) || (q_if.size() == 1 && q_if[0].rdy == cyc && ifr);
      ld_el = (q_ld.size() == 0) || (q_ld.size() == 1 && q_ld[0].rdy == cyc && ldr);
      ld_w  = ldv && ld_el && (!(ifv && if_el) || starve == STARVE_LIMIT);
      if_w  = ifv && if_el && !ld_w;
      e_addr = if_w ? ifa : (ld_w ? lda : last_addr);
      e_ifv  = (q_if.size() != 0) && !ifl;
      e_ldv  = (q_ld.size() != 0);

      chk("if_req_ready", {31'b0, IF_REQ_READY}, {31'b0, if_w});
      chk("ld_req_ready", {31'b0, LD_REQ_READY}, {31'b0, ld_w});
      chk("rom_addr", ROM_ADDR, e_addr);
      chk("if_rsp_valid", {31'b0, IF_RSP_VALID}, {31'b0, e_ifv});
      if (e_ifv) chk("if_rsp_data", IF_RSP_DATA, q_if[0].data);
      chk("ld_rsp_valid", {31'b0, LD_RSP_VALID}, {31'b0, e_ldv});
      if (e_ldv) begin
         chk("ld_rsp_data", LD_RSP_DATA, q_ld[0].data);
         chk("ld_rsp_err", {31'b0, LD_RSP_ERR}, {31'b0, q_ld[0].err});
      end

      s_if_req_ready = IF_REQ_READY;
      s_ld_req_ready = LD_REQ_READY;
      s_rom_addr     = ROM_ADDR;
      s_if_rsp_valid = IF_RSP_VALID;
      s_if_rsp_data  = IF_RSP_DATA;
      s_ld_rsp_valid = LD_RSP_VALID;
      s_ld_rsp_data  = LD_RSP_DATA;
      s_ld_rsp_err   = LD_RSP_ERR;

      if (ifl) q_if.delete();
      else if (e_ifv && ifr) void'(q_if.pop_front());
      if (e_ldv && ldr) void'(q_ld.pop_front());
      if (if_w) q_if.push_back('{rom_word(ifa), 1'b0, cyc + 1});
      if (ld_w) q_ld.push_back('{rom_word(lda), (lda[1:0] != 2'b00), cyc + 1});
      if (!ldv || ld_w) starve = 0;
      else if (ld_el && starve < STARVE_LIMIT) starve++;
      if (if_w || ld_w) last_addr = e_addr;
      cyc++;

      @(posedge CLK);
      #1;
      ROM_DATA = rom_word(s_rom_addr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
   endtask

   initial begin
      int          deliveries;
      logic [9:0]  ld_mask;
      logic        ifv, ifl, ifr, ldv, ldr;
      logic [31:0] ifa, lda;

      RST_N = 1'b0;
      IF_REQ_VALID = 1'b1; IF_ADDR = 32'h44; IF_FLUSH = 1'b0; IF_RSP_READY = 1'b1;
      LD_REQ_VALID = 1'b1; LD_ADDR = 32'h88; LD_RSP_READY = 1'b1;
      ROM_DATA = '0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      chk("reset_if_req_ready", {31'b0, IF_REQ_READY}, 32'd0);
      chk("reset_ld_req_ready", {31'b0, LD_REQ_READY}, 32'd0);
      chk("reset_if_rsp_valid", {31'b0, IF_RSP_VALID}, 32'd0);
      chk("reset_ld_rsp_valid", {31'b0, LD_RSP_VALID}, 32'd0);
      chk("reset_rom_addr", ROM_ADDR, 32'h0);
      model_reset();
      RST_N = 1'b1;

      // single fetch
      cycle(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("fetch_grant", {31'b0, s_if_req_ready}, 32'd1);
      chk("fetch_rom_addr", s_rom_addr, 32'h10);
      idle(1);
      chk("fetch_rsp_valid", {31'b0, s_if_rsp_valid}, 32'd1);
      chk("fetch_rsp_data", s_if_rsp_data, rom_word(32'h10));
      idle(1);

      // both requesters saturating: LD wins every fifth grant
      ld_mask = '0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b1, 1'b1, 32'h200 + 32'(4 * i), 1'b1);
         ld_mask[i] = s_ld_req_ready;
      end
      chk("starve_pattern", {22'b0, ld_mask}, 32'h210);
      idle(2);

      // response held while the fetch consumer stalls
      deliveries = 0;
      cycle(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 32'h20, 1'b0, (i == 3), 1'b0, 32'h0, 1'b1);
         chk("hold_req_ready", {31'b0, s_if_req_ready}, 32'd0);
         chk("hold_rsp_valid", {31'b0, s_if_rsp_valid}, 32'd1);
         chk("hold_rsp_data", s_if_rsp_data, rom_word(32'h20));
         if (s_if_rsp_valid && i == 3) deliveries++;
      end
      idle(1);
      if (s_if_rsp_valid) deliveries++;
      chk("hold_deliveries", 32'(deliveries), 32'd1);
      idle(1);

      // flush drops the old fetch, the same-cycle request is served
      cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("flush_old_hidden", {31'b0, s_if_rsp_valid}, 32'd0);
      chk("flush_new_grant", {31'b0, s_if_req_ready}, 32'd1);
      chk("flush_new_addr", s_rom_addr, 32'h100);
      idle(1);
      chk("flush_new_valid", {31'b0, s_if_rsp_valid}, 32'd1);
      chk("flush_new_data", s_if_rsp_data, rom_word(32'h100));
      idle(1);

      // misaligned load followed by an aligned one
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h6, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8, 1'b1);
      chk("misal_valid", {31'b0, s_ld_rsp_valid}, 32'd1);
      chk("misal_data", s_ld_rsp_data, rom_word(32'h4));
      chk("misal_err", {31'b0, s_ld_rsp_err}, 32'd1);
      idle(1);
      chk("aligned_data", s_ld_rsp_data, rom_word(32'h8));
      chk("aligned_err", {31'b0, s_ld_rsp_err}, 32'd0);
      idle(1);

      // reset between grant and response
      cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      IF_REQ_VALID = 1'b1;
      LD_REQ_VALID = 1'b1;
      RST_N = 1'b0;
      #1;
      chk("midrst_if_rsp_valid", {31'b0, IF_RSP_VALID}, 32'd0);
      chk("midrst_ld_rsp_valid", {31'b0, LD_RSP_VALID}, 32'd0);
      chk("midrst_if_req_ready", {31'b0, IF_REQ_READY}, 32'd0);
      chk("midrst_ld_req_ready", {31'b0, LD_REQ_READY}, 32'd0);
      chk("midrst_rom_addr", ROM_ADDR, 32'h0);
      model_reset();
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      idle(3);
      chk("postrst_no_rsp", {31'b0, s_if_rsp_valid}, 32'd0);
      cycle(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      idle(1);
      chk("postrst_resume", s_if_rsp_data, rom_word(32'h80));

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         ifv = ($urandom_range(0, 3) != 0);
         ldv = ($urandom_range(0, 1) != 0);
         ifr = ($urandom_range(0, 3) != 0);
         ldr = ($urandom_range(0, 3) != 0);
         ifl = ($urandom_range(0, 15) == 0);
         ifa = $urandom & 32'hFFFF_FFFC;
         lda = $urandom;
         cycle(ifv, ifa, ifl, ifr, ldv, lda, ldr);
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
